circ_buf_trig_addr_gen: RTL and testbench

// Upstream of the circular-buffer-to-DDR3 sequencer. Runs the circular buffer write address,

---
 rtl/circ_buf_trig_addr_gen.sv | 192 +++++++++++++++++++
 tb/tb_circ_buf_trig_addr_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/circ_buf_trig_addr_gen.sv
// Circular-buffer write address generator with trigger capture and a FWFT start-address FIFO.
// Optional TRIG_TIMESTAMP_EN stores a free-running cycle count with each queued start address.
module circ_buf_trig_addr_gen #(
  parameter int ADR_WIDTH       = 12,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 adc_clk,
  input  logic                 reset_clk_adc_n,
  input  logic                 acq_en,
  input  logic                 trig_in,
  input  logic [ADR_WIDTH-1:0] pre_trig_words,
  input  logic [ADR_WIDTH-1:0] waveform_words,
  output logic [ADR_WIDTH-1:0] circ_buf_wr_addr,
  output logic                 circ_buf_wr_en,
  input  logic                 trig_addr_rd_en,
  output logic                 trig_fifo_empty,
  output logic [ADR_WIDTH-1:0] trig_addr,
  output logic                 trig_fifo_full,
  output logic [15:0]          trig_dropped_cnt,
`ifdef TRIG_TIMESTAMP_EN
  output logic [31:0]          trig_timestamp,
`endif
  output logic [1:0]           fsm_state
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW         = FIFO_DEPTH_LOG2 + 1;
`ifdef TRIG_TIMESTAMP_EN
  localparam int FW = ADR_WIDTH + 32;
`else
  localparam int FW = ADR_WIDTH;
`endif

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    ARMED     = 2'd1,
    POST_TRIG = 2'd2,
    PUSH      = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic                   trig_prev;
  logic                   trig_edge;
  logic [ADR_WIDTH-1:0]   start_addr;
  logic [ADR_WIDTH-1:0]   start_calc;
  logic [ADR_WIDTH-1:0]   post_cnt;
  logic [ADR_WIDTH-1:0]   post_calc;
  logic                   load_trig;
  logic                   push_req;
  logic                   trig_drop;
  logic                   full_drop;
  logic [1:0]             drop_inc;
  logic [16:0]            drop_sum;

  logic [FW-1:0]              fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              fifo_count, fifo_count_next;
  logic                       fifo_push, fifo_pop;
  logic [FW-1:0]              fifo_din, fifo_head;

  assign fsm_state  = state;
  assign trig_edge  = trig_in & ~trig_prev;
  assign start_calc = circ_buf_wr_addr - pre_trig_words;
  assign post_calc  = (waveform_words >= pre_trig_words) ? (waveform_words - pre_trig_words)
                                                        : '0;

  // Write address, write strobe and trigger history
  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      circ_buf_wr_addr <= '0;
      circ_buf_wr_en   <= 1'b0;
      trig_prev        <= 1'b0;
    end else begin
      circ_buf_wr_en <= acq_en;
      trig_prev      <= trig_in;
      if (acq_en) circ_buf_wr_addr <= circ_buf_wr_addr + 1'b1;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) state <= DISABLED;
    else                  state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_trig  = 1'b0;
    push_req   = 1'b0;
    trig_drop  = 1'b0;
    case (state)
      DISABLED:  if (acq_en) state_next = ARMED;
      ARMED: begin
        if (trig_edge) begin
          state_next = POST_TRIG;
          load_trig  = 1'b1;
        end
      end
      POST_TRIG: begin
        trig_drop = trig_edge;
        if (post_cnt == '0) state_next = PUSH;
      end
      PUSH: begin
        trig_drop  = trig_edge;
        push_req   = 1'b1;
        state_next = ARMED;
      end
      default:   state_next = DISABLED;
    endcase
    // Dropping acq_en aborts any waveform in flight; nothing is queued or counted.
    if (!acq_en) begin
      state_next = DISABLED;
      load_trig  = 1'b0;
      push_req   = 1'b0;
      trig_drop  = 1'b0;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      start_addr <= '0;
      post_cnt   <= '0;
    end else if (load_trig) begin
      start_addr <= start_calc;
      post_cnt   <= post_calc;
    end else if (state == POST_TRIG && post_cnt != '0) begin
      post_cnt <= post_cnt - 1'b1;
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] start_ts;

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      cycle_cnt <= '0;
      start_ts  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (load_trig) start_ts <= cycle_cnt;
    end
  end

  assign fifo_din       = {start_ts, start_addr};
  assign trig_timestamp = trig_fifo_empty ? 32'd0 : fifo_head[FW-1:ADR_WIDTH];
`else
  assign fifo_din = start_addr;
`endif

  // A push into a full FIFO still succeeds when a pop happens on the same edge.
  assign fifo_pop  = trig_addr_rd_en & ~trig_fifo_empty;
  assign fifo_push = push_req & (~trig_fifo_full | fifo_pop);
  assign full_drop = push_req & trig_fifo_full & ~fifo_pop;
  assign drop_inc  = {1'b0, trig_drop} + {1'b0, full_drop};
  assign drop_sum  = {1'b0, trig_dropped_cnt} + {15'd0, drop_inc};

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n)  trig_dropped_cnt <= '0;
    else if (drop_sum[16]) trig_dropped_cnt <= 16'hFFFF;
    else                   trig_dropped_cnt <= drop_sum[15:0];
  end

  always_comb begin
    fifo_count_next = fifo_count;
    if (fifo_push && !fifo_pop)      fifo_count_next = fifo_count + 1'b1;
    else if (fifo_pop && !fifo_push) fifo_count_next = fifo_count - 1'b1;
  end

  always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
    if (!reset_clk_adc_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      trig_fifo_empty <= 1'b1;
      trig_fifo_full  <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count      <= fifo_count_next;
      trig_fifo_empty <= (fifo_count_next == '0);
      trig_fifo_full  <= (fifo_count_next == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge adc_clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= fifo_din;
  end

  assign fifo_head = fifo_mem[rd_ptr];
  assign trig_addr = trig_fifo_empty ? '0 : fifo_head[ADR_WIDTH-1:0];

endmodule

// File: tb/tb_circ_buf_trig_addr_gen.sv
// Bench for circ_buf_trig_addr_gen: directed scenarios plus random traffic against a
// time-stamped reference model (each trigger schedules its push edge arithmetically).
module tb_circ_buf_trig_addr_gen;
  localparam int AW   = 12;
  localparam int MASK = (1 << AW) - 1;
  localparam int DEP  = 16;

  logic          adc_clk = 1'b0;
  logic          reset_clk_adc_n;
  logic          acq_en, trig_in, trig_addr_rd_en;
  logic [AW-1:0] pre_trig_words, waveform_words;
  logic [AW-1:0] circ_buf_wr_addr, trig_addr;
  logic          circ_buf_wr_en, trig_fifo_empty, trig_fifo_full;
  logic [15:0]   trig_dropped_cnt;
  logic [1:0]    fsm_state;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0]   trig_timestamp;
`endif

  circ_buf_trig_addr_gen #(.ADR_WIDTH(AW), .FIFO_DEPTH_LOG2(4)) dut (
    .adc_clk          (adc_clk),
    .reset_clk_adc_n  (reset_clk_adc_n),
    .acq_en           (acq_en),
    .trig_in          (trig_in),
    .pre_trig_words   (pre_trig_words),
    .waveform_words   (waveform_words),
    .circ_buf_wr_addr (circ_buf_wr_addr),
    .circ_buf_wr_en   (circ_buf_wr_en),
    .trig_addr_rd_en  (trig_addr_rd_en),
    .trig_fifo_empty  (trig_fifo_empty),
    .trig_addr        (trig_addr),
    .trig_fifo_full   (trig_fifo_full),
    .trig_dropped_cnt (trig_dropped_cnt),
`ifdef TRIG_TIMESTAMP_EN
    .trig_timestamp   (trig_timestamp),
`endif
    .fsm_state        (fsm_state)
  );

  // clock / reset
  always #5 adc_clk = ~adc_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: waveform in flight is described by its scheduled push edge
  logic [AW-1:0] exp_q[$];
  int  m_addr, m_drop, m_cyc;
  bit  m_prev_trig, m_prev_acq, m_pend;
  int  m_pend_t;
  int  m_pend_addr;

  function automatic void model_reset();
    exp_q.delete();
    m_addr = 0; m_drop = 0; m_cyc = 0;
    m_prev_trig = 0; m_prev_acq = 0; m_pend = 0; m_pend_t = 0; m_pend_addr = 0;
  endfunction

  function automatic void model_step(input bit a, input bit t, input bit r, input int pre, input int wav);
    bit edge_seen, pop, push;
    int post;
    edge_seen = t && !m_prev_trig;
    pop  = r && (exp_q.size() > 0);
    push = 0;
    if (!a) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (edge_seen) m_drop++;
      if (m_cyc == m_pend_t) begin
        m_pend = 0;
        if (exp_q.size() < DEP || pop) push = 1;
        else m_drop++;
      end
    end else if (m_prev_acq && edge_seen) begin
      post        = (wav > pre) ? wav - pre : 0;
      m_pend      = 1;
      m_pend_addr = (m_addr - pre) & MASK;
      m_pend_t    = m_cyc + post + 2;
    end
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(AW'(m_pend_addr));
    if (m_drop > 65535) m_drop = 65535;
    if (a) m_addr = (m_addr + 1) & MASK;
    m_prev_trig = t;
    m_prev_acq  = a;
    m_cyc++;
  endfunction

  task automatic compare_all();
    check("wr_addr", 32'(circ_buf_wr_addr), 32'(m_addr));
    check("wr_en",   32'(circ_buf_wr_en),   32'(m_prev_acq));
    check("empty",   32'(trig_fifo_empty),  32'(exp_q.size() == 0));
    check("full",    32'(trig_fifo_full),   32'(exp_q.size() == DEP));
    check("head",    32'(trig_addr),        (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    check("dropped", 32'(trig_dropped_cnt), 32'(m_drop));
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 ns after the rising edge
  task automatic step(input bit a, input bit t, input bit r);
    @(negedge adc_clk);
    acq_en = a; trig_in = t; trig_addr_rd_en = r;
    @(posedge adc_clk);
    model_step(a, t, r, int'(pre_trig_words), int'(waveform_words));
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(circ_buf_wr_addr), 32'd0);
    check({tag, "_wren"},  32'(circ_buf_wr_en),   32'd0);
    check({tag, "_empty"}, 32'(trig_fifo_empty),  32'd1);
    check({tag, "_full"},  32'(trig_fifo_full),   32'd0);
    check({tag, "_head"},  32'(trig_addr),        32'd0);
    check({tag, "_drop"},  32'(trig_dropped_cnt), 32'd0);
  endtask

  initial begin
    int a0;
    logic [AW-1:0] exp_head;
    reset_clk_adc_n = 1'b0;
    acq_en = 0; trig_in = 0; trig_addr_rd_en = 0;
    pre_trig_words = 12'd16; waveform_words = 12'd64;
    model_reset();
    repeat (3) @(posedge adc_clk);
    #1;
    check_reset_outputs("rst");
    #1 reset_clk_adc_n = 1'b1;

    // 1: trigger at write address 100, start 84 after post+2 = 50 edges
    while (m_addr != 100) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);              // level held: still one trigger
    idle(48, 0);
    check("t1_not_yet", 32'(trig_fifo_empty), 32'd1);
    idle(1, 0);
    check("t1_empty", 32'(trig_fifo_empty), 32'd0);
    check("t1_addr",  32'(trig_addr), 32'd84);
    idle(1, 1);

    // 2: address wrap and start-address wrap below zero
    while (m_addr != 4095) step(1, 0, 0);
    step(1, 0, 0);
    check("t2_wrap", 32'(circ_buf_wr_addr), 32'd0);
    while (m_addr != 5) step(1, 0, 0);
    step(1, 1, 0);
    idle(50, 0);
    check("t2_addr", 32'(trig_addr), 32'd4085);
    idle(1, 1);

    // 3: second trigger during POST_TRIG is dropped
    step(1, 1, 0);
    idle(9, 0);
    step(1, 1, 0);
    idle(45, 0);
    check("t3_drop", 32'(trig_dropped_cnt), 32'd1);
    check("t3_one",  32'(trig_fifo_empty),  32'd0);
    idle(1, 1);
    check("t3_drained", 32'(trig_fifo_empty), 32'd1);

    // 4: fill FIFO, overflow drop, pop+push while full
    pre_trig_words = 12'd2; waveform_words = 12'd4;
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 0);
      idle(4, 0);
    end
    check("t4_full", 32'(trig_fifo_full), 32'd1);
    step(1, 1, 0);
    idle(4, 0);
    check("t4_drop", 32'(trig_dropped_cnt), 32'd2);
    exp_head = exp_q[1];
    step(1, 1, 0);
    idle(3, 0);
    idle(1, 1);
    check("t4_full_pp", 32'(trig_fifo_full), 32'd1);
    check("t4_head_pp", 32'(trig_addr), 32'(exp_head));
    idle(16, 1);
    check("t4_empty", 32'(trig_fifo_empty), 32'd1);

    // 5: acq_en drop aborts, then reset mid-POST_TRIG
    pre_trig_words = 12'd16; waveform_words = 12'd64;
    step(1, 1, 0);
    idle(10, 0);
    a0 = m_addr;
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    check("t5_frozen", 32'(circ_buf_wr_addr), 32'(a0));
    idle(60, 0);
    check("t5_nopush", 32'(trig_fifo_empty), 32'd1);
    step(1, 1, 0);
    idle(10, 0);
    @(negedge adc_clk);
    reset_clk_adc_n = 1'b0;
    acq_en = 0; trig_in = 0; trig_addr_rd_en = 0;
    #1;
    check_reset_outputs("t5_rst");
    model_reset();
    @(posedge adc_clk);
    #2 reset_clk_adc_n = 1'b1;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        pre_trig_words = AW'($urandom_range(0, 40));
        waveform_words = AW'($urandom_range(0, 60));
      end
      step(($urandom_range(0, 99) < 95), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
